// File: rtl/layer_mac_engine.sv
// Fully-connected layer y = act(W*x + b): weights/biases streamed from registered ROMs, DATA_N MACs per cycle.
// Latency NSTEP+2 cycles from accept to valid; no backpressure, run ignored while busy.
module layer_mac_engine #(
    parameter int IN_DIM  = 16,
    parameter int OUT_DIM = 16,
    parameter int DATA_N  = 4,
    parameter int N_LEN   = 16,
    parameter int FRAC    = 8,
    localparam int CHUNKS  = IN_DIM / DATA_N,
    localparam int NSTEP   = OUT_DIM * CHUNKS,
    localparam int ACC_LEN = 2 * N_LEN + $clog2(IN_DIM) + 1,
    localparam int AW      = (NSTEP > 1) ? $clog2(NSTEP) : 1,
    localparam int BW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1,
    localparam int CW      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      mode,
    input  logic [IN_DIM*N_LEN-1:0]   data_in,
    output logic [AW-1:0]             w_addr,
    input  logic [DATA_N*N_LEN-1:0]   w_data,
    output logic [BW-1:0]             b_addr,
    input  logic [N_LEN-1:0]          b_data,
    output logic                      busy,
    output logic                      valid,
    output logic [OUT_DIM*N_LEN-1:0]  data_out
);

    generate
        if (IN_DIM % DATA_N != 0) begin : g_chk_div
            $error("IN_DIM must be a multiple of DATA_N");
        end
        if (FRAC >= N_LEN) begin : g_chk_frac
            $error("FRAC must be smaller than N_LEN");
        end
    endgenerate

    localparam logic signed [ACC_LEN-1:0] SAT_MAX = {{(ACC_LEN-N_LEN+1){1'b0}}, {(N_LEN-1){1'b1}}};
    localparam logic signed [ACC_LEN-1:0] SAT_MIN = {{(ACC_LEN-N_LEN+1){1'b1}}, {(N_LEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [IN_DIM*N_LEN-1:0] x_reg;
    logic                    mode_q;
    logic [CW-1:0]           c_cnt;
    logic [BW-1:0]           o_cnt;
    logic                    accept;
    logic                    last_step;

    logic                    p_vld;
    logic [CW-1:0]           p_c;
    logic [BW-1:0]           p_o;

    logic signed [ACC_LEN-1:0] acc;
    logic signed [N_LEN-1:0]   bias_q;

    logic [DATA_N*N_LEN-1:0]   x_chunk;
    logic signed [2*N_LEN-1:0] lane_p;
    logic signed [ACC_LEN-1:0] prod;
    logic signed [ACC_LEN-1:0] acc_base;
    logic signed [N_LEN-1:0]   bias_cur;
    logic signed [ACC_LEN-1:0] sum;
    logic signed [ACC_LEN-1:0] scaled;
    logic signed [N_LEN-1:0]   res;

    assign accept    = (state == IDLE) && run;
    assign last_step = (w_addr == AW'(NSTEP - 1));
    assign busy      = (state != IDLE);
    assign valid     = (state == DONE);
    assign b_addr    = o_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = ISSUE;
            ISSUE:   if (last_step) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address sequencer: one weight word per cycle, bias address follows the output index.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg  <= '0;
            mode_q <= 1'b0;
            w_addr <= '0;
            c_cnt  <= '0;
            o_cnt  <= '0;
        end else if (accept) begin
            x_reg  <= data_in;
            mode_q <= mode;
            w_addr <= '0;
            c_cnt  <= '0;
            o_cnt  <= '0;
        end else if (state == ISSUE && !last_step) begin
            w_addr <= w_addr + AW'(1);
            if (c_cnt == CW'(CHUNKS - 1)) begin
                c_cnt <= '0;
                o_cnt <= o_cnt + BW'(1);
            end else begin
                c_cnt <= c_cnt + CW'(1);
            end
        end
    end

    // Step tag delayed to line up with the ROM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_vld <= 1'b0;
            p_c   <= '0;
            p_o   <= '0;
        end else begin
            p_vld <= (state == ISSUE);
            p_c   <= c_cnt;
            p_o   <= o_cnt;
        end
    end

    always_comb begin
        x_chunk = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            if (p_c == CW'(c)) x_chunk = x_reg[c*DATA_N*N_LEN +: DATA_N*N_LEN];
        end
        prod   = '0;
        lane_p = '0;
        for (int l = 0; l < DATA_N; l++) begin
            lane_p = $signed(x_chunk[l*N_LEN +: N_LEN]) * $signed(w_data[l*N_LEN +: N_LEN]);
            prod   = prod + ACC_LEN'(lane_p);
        end
        acc_base = (p_c == '0) ? '0 : acc;
        // With a single chunk the bias word arrives in the same cycle it is consumed.
        bias_cur = (p_c == '0) ? $signed(b_data) : bias_q;
        sum      = acc_base + prod + (ACC_LEN'(bias_cur) <<< FRAC);
        scaled   = sum >>> FRAC;
        if (scaled > SAT_MAX) begin
            res = SAT_MAX[N_LEN-1:0];
        end else if (scaled < SAT_MIN) begin
            res = SAT_MIN[N_LEN-1:0];
        end else begin
            res = scaled[N_LEN-1:0];
        end
        if (mode_q && res[N_LEN-1]) res = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            bias_q   <= '0;
            data_out <= '0;
        end else if (p_vld) begin
            acc <= acc_base + prod;
            if (p_c == '0) bias_q <= $signed(b_data);
            if (p_c == CW'(CHUNKS - 1)) begin
                for (int o = 0; o < OUT_DIM; o++) begin
                    if (p_o == BW'(o)) data_out[o*N_LEN +: N_LEN] <= res;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_mac_engine.sv
// Scoreboarded bench: small 4x2 instance for directed corners, default instance for random vectors and reset abort.
module tb_layer_mac_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // small instance: IN_DIM=4, OUT_DIM=2, DATA_N=4 -> NSTEP=2
    logic        s_run = 1'b0, s_mode = 1'b0;
    logic [63:0] s_din = '0;
    logic [0:0]  s_waddr, s_baddr;
    logic [63:0] s_wdata = '0;
    logic [15:0] s_bdata = '0;
    logic        s_busy, s_valid;
    logic [31:0] s_dout;

    // default instance: IN_DIM=16, OUT_DIM=16, DATA_N=4 -> NSTEP=64
    logic         d_run = 1'b0, d_mode = 1'b0;
    logic [255:0] d_din = '0;
    logic [5:0]   d_waddr;
    logic [3:0]   d_baddr;
    logic [63:0]  d_wdata = '0;
    logic [15:0]  d_bdata = '0;
    logic         d_busy, d_valid;
    logic [255:0] d_dout;

    layer_mac_engine #(.IN_DIM(4), .OUT_DIM(2), .DATA_N(4), .N_LEN(16), .FRAC(8)) u_small (
        .clk(clk), .rst(rst), .run(s_run), .mode(s_mode), .data_in(s_din),
        .w_addr(s_waddr), .w_data(s_wdata), .b_addr(s_baddr), .b_data(s_bdata),
        .busy(s_busy), .valid(s_valid), .data_out(s_dout)
    );

    layer_mac_engine u_dflt (
        .clk(clk), .rst(rst), .run(d_run), .mode(d_mode), .data_in(d_din),
        .w_addr(d_waddr), .w_data(d_wdata), .b_addr(d_baddr), .b_data(d_bdata),
        .busy(d_busy), .valid(d_valid), .data_out(d_dout)
    );

    int sx[4];
    int sw[2][4];
    int sb[2];
    int dx[16];
    int dw[16][16];
    int db[16];

    // ROM models, one-cycle registered read
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) s_wdata[l*16 +: 16] <= 16'(sw[s_waddr][l]);
        s_bdata <= 16'(sb[s_baddr]);
        for (int l = 0; l < 4; l++) d_wdata[l*16 +: 16] <= 16'(dw[int'(d_waddr) / 4][(int'(d_waddr) % 4) * 4 + l]);
        d_bdata <= 16'(db[d_baddr]);
    end

    logic [31:0]  s_q[$];
    int           s_tq[$];
    logic [255:0] d_q[$];
    int           d_tq[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] fin(input longint dot, input int b, input bit m);
        longint s;
        s = (dot + longint'(b) * 256) >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (m && s < 0) s = 0;
        return 16'(s);
    endfunction

    function automatic logic [31:0] s_model(input bit m);
        logic [31:0] r;
        longint dot;
        r = '0;
        for (int o = 0; o < 2; o++) begin
            dot = 0;
            for (int i = 0; i < 4; i++) dot += longint'(sx[i]) * longint'(sw[o][i]);
            r[o*16 +: 16] = fin(dot, sb[o], m);
        end
        return r;
    endfunction

    function automatic logic [255:0] d_model(input bit m);
        logic [255:0] r;
        longint dot;
        r = '0;
        for (int o = 0; o < 16; o++) begin
            dot = 0;
            for (int i = 0; i < 16; i++) dot += longint'(dx[i]) * longint'(dw[o][i]);
            r[o*16 +: 16] = fin(dot, db[o], m);
        end
        return r;
    endfunction

    // monitors
    always @(negedge clk) begin
        if (!rst && s_valid) begin
            if (s_q.size() == 0) begin
                chk("s_unexpected_valid", 1, 0);
            end else begin
                chk("s_data", s_dout, s_q.pop_front());
                chk("s_latency", cyc, s_tq.pop_front());
            end
        end
        if (!rst && d_valid) begin
            if (d_q.size() == 0) begin
                chk("d_unexpected_valid", 1, 0);
            end else begin
                chk("d_data", d_dout, d_q.pop_front());
                chk("d_latency", cyc, d_tq.pop_front());
            end
        end
    end

    task automatic s_go(input bit m);
        int t;
        @(negedge clk);
        for (int i = 0; i < 4; i++) s_din[i*16 +: 16] = 16'(sx[i]);
        s_mode = m;
        s_run = 1'b1;
        t = cyc;
        s_q.push_back(s_model(m));
        s_tq.push_back(t + 4);
        @(negedge clk);
        s_run = 1'b0;
        chk("s_busy_after_accept", s_busy, 1);
        for (int i = 0; i < 20 && s_busy; i++) @(negedge clk);
        chk("s_busy_falls", s_busy, 0);
        @(negedge clk);
    endtask

    task automatic d_go(input bit m, input bit extra);
        int t;
        @(negedge clk);
        for (int i = 0; i < 16; i++) d_din[i*16 +: 16] = 16'(dx[i]);
        d_mode = m;
        d_run = 1'b1;
        t = cyc;
        d_q.push_back(d_model(m));
        d_tq.push_back(t + 66);
        @(negedge clk);
        d_run = 1'b0;
        chk("d_busy_after_accept", d_busy, 1);
        if (extra) begin
            repeat (2) @(negedge clk);
            d_run = 1'b1;
            d_mode = ~m;
            d_din = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            d_run = 1'b0;
            while (cyc < t + 66) @(negedge clk);
            d_run = 1'b1;
            @(negedge clk);
            d_run = 1'b0;
        end
        for (int i = 0; i < 100 && d_busy; i++) @(negedge clk);
        chk("d_busy_falls", d_busy, 0);
        repeat (70) @(negedge clk);
    endtask

    task automatic d_randomize();
        for (int i = 0; i < 16; i++) begin
            dx[i] = int'($urandom_range(0, 2047)) - 1024;
            db[i] = int'($urandom_range(0, 8191)) - 4096;
            for (int o = 0; o < 16; o++) dw[o][i] = int'($urandom_range(0, 2047)) - 1024;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        foreach (sx[i]) sx[i] = 0;
        foreach (sb[i]) sb[i] = 0;
        foreach (sw[o, i]) sw[o][i] = 0;
        d_randomize();

        repeat (3) @(negedge clk);
        chk("rst_s_busy", s_busy, 0);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_s_dout", s_dout, 0);
        chk("rst_s_addr", {s_waddr, s_baddr}, 0);
        chk("rst_d_busy", d_busy, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_d_dout", d_dout, 0);
        chk("rst_d_addr", {d_waddr, d_baddr}, 0);
        rst = 1'b0;
        @(negedge clk);

        // unity weights and inputs: 4 * 1.0 * 1.0 = 4.0
        foreach (sx[i]) sx[i] = 256;
        foreach (sw[o, i]) sw[o][i] = 256;
        s_go(1'b0);
        chk("t1_const", s_dout, {16'h0400, 16'h0400});

        // negative weights plus half bias, linear then ReLU
        foreach (sw[o, i]) sw[o][i] = -256;
        foreach (sb[o]) sb[o] = 128;
        s_go(1'b0);
        chk("t2_linear_const", s_dout, {16'hFC80, 16'hFC80});
        s_go(1'b1);
        chk("t2_relu_const", s_dout, 32'h0);

        // saturation on both rails
        foreach (sb[o]) sb[o] = 0;
        foreach (sx[i]) sx[i] = 32767;
        foreach (sw[o, i]) sw[o][i] = 32767;
        s_go(1'b0);
        chk("t3_pos_sat", s_dout, {16'h7FFF, 16'h7FFF});
        foreach (sw[o, i]) sw[o][i] = -32768;
        s_go(1'b0);
        chk("t3_neg_sat", s_dout, {16'h8000, 16'h8000});

        // floor rounding of tiny products
        foreach (sx[i]) sx[i] = 0;
        foreach (sw[o, i]) sw[o][i] = 0;
        sx[0] = 1;
        sw[0][0] = -1;
        s_go(1'b0);
        chk("t4_floor_neg", s_dout, {16'h0000, 16'hFFFF});
        sx[0] = 255;
        sw[0][0] = 1;
        s_go(1'b0);
        chk("t4_floor_pos", s_dout, 32'h0);

        // default-size random runs, first one with ignored run pulses and input changes while busy
        d_go(1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            d_randomize();
            d_go(r[0], 1'b0);
        end

        // reset abort in cycle 5 of a run
        d_randomize();
        @(negedge clk);
        for (int i = 0; i < 16; i++) d_din[i*16 +: 16] = 16'(dx[i]);
        d_mode = 1'b0;
        d_run = 1'b1;
        t = cyc;
        @(negedge clk);
        d_run = 1'b0;
        while (cyc < t + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", d_busy, 0);
        chk("abort_valid", d_valid, 0);
        chk("abort_dout", d_dout, 0);
        chk("abort_waddr", d_waddr, 0);
        repeat (75) @(negedge clk);
        d_go(1'b1, 1'b0);

        chk("s_queue_empty", s_q.size(), 0);
        chk("d_queue_empty", d_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
